// File: rtl/ppg_afe_model.sv
// ppg_afe_model: digital stand-in for the pulse-oximeter analog front end (LED, photodiode, DC comp, PGA, 8-bit ADC).
module ppg_afe_model #(
  parameter int PERIOD     = 1000,
  parameter int AC_STEP    = 16,
  parameter int DC_RED     = 140,
  parameter int DC_IR      = 160,
  parameter int AMBIENT    = 8,
  parameter int DC_LSB     = 2,
  parameter int MID        = 127,
  parameter int SETTLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       LED_IR,
  input  logic       LED_RED,
  input  logic [3:0] LED_Drive,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  output logic [7:0] Vppg,
  output logic       Vppg_valid,
  output logic [9:0] pulse_phase
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  logic [9:0] phase_q, phase_d;
  logic [15:0] ac_acc_q, ac_acc_d;
  logic [7:0] ac;
  logic [4:0] drv;
  logic [13:0] red_m, ir_m;
  logic [10:0] red, ir;
  logic [11:0] both;
  logic [9:0] sig_q, sig_d;
  logic [3:0] gain_q;
  logic [6:0] comp_q;
  logic signed [15:0] diff, gmul, v;
  logic signed [14:0] d_q, d_d;
  logic [7:0] vppg_q, vppg_d;
  logic valid_q;
  logic [5:0] led, prev_led_q;
  logic [SW-1:0] settle_q, settle_d;
  always_comb begin
    phase_d  = (phase_q == 10'(PERIOD - 1)) ? '0 : phase_q + 10'd1;
    ac_acc_d = (phase_q == 10'(PERIOD - 1)) ? '0 :
               (phase_q < 10'(PERIOD / 2)) ? ac_acc_q + 16'(AC_STEP) : ac_acc_q - 16'(AC_STEP);
    ac    = ac_acc_q[15:8];
    drv   = {1'b0, LED_Drive} + 5'd1;
    red_m = (14'(DC_RED) + 14'(ac)) * 14'(drv);
    ir_m  = (14'(DC_IR) + 14'(ac) + 14'(ac >> 1)) * 14'(drv);
    red   = 11'(red_m >> 3);
    ir    = 11'(ir_m >> 3);
    both  = 12'(red) + 12'(ir);
    sig_d = (LED_RED && LED_IR) ? ((both > 12'd1023) ? 10'd1023 : both[9:0]) :
            LED_RED ? ((red > 11'd1023) ? 10'd1023 : red[9:0]) :
            LED_IR  ? ((ir > 11'd1023) ? 10'd1023 : ir[9:0]) : 10'(AMBIENT);
    // differences may go negative; the signed product fits 15 bits for every legal input
    diff  = 16'(sig_q) - 16'(comp_q * DC_LSB);
    gmul  = 16'(gain_q) + 16'sd1;
    d_d   = 15'(diff * gmul);
    v     = 16'sd0 + 16'(MID) + {{1{d_q[14]}}, d_q};
    vppg_d = (v < 16'sd0) ? 8'd0 : (v > 16'sd255) ? 8'd255 : v[7:0];
    led   = {LED_IR, LED_RED, LED_Drive};
    settle_d = (led != prev_led_q) ? SW'(SETTLE_CYC) :
               (settle_q == '0) ? '0 : settle_q - 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      phase_q    <= '0;
      ac_acc_q   <= '0;
      sig_q      <= '0;
      gain_q     <= '0;
      comp_q     <= '0;
      d_q        <= '0;
      vppg_q     <= 8'(MID);
      valid_q    <= 1'b0;
      prev_led_q <= '0;
      settle_q   <= SW'(SETTLE_CYC);
    end else begin
      phase_q    <= phase_d;
      ac_acc_q   <= ac_acc_d;
      sig_q      <= sig_d;
      gain_q     <= PGA_Gain;
      comp_q     <= DC_Comp;
      d_q        <= d_d;
      if (settle_d == '0) vppg_q <= vppg_d;
      valid_q    <= (settle_d == '0);
      prev_led_q <= led;
      settle_q   <= settle_d;
    end
  end
  assign Vppg        = vppg_q;
  assign Vppg_valid  = valid_q;
  assign pulse_phase = phase_q;
endmodule

// File: tb/tb_ppg_afe_model.sv
// tb_ppg_afe_model: directed vector table plus timing sequences for the AFE emulator.
module tb_ppg_afe_model;
  logic CLK = 0;
  logic rst = 1;
  logic LED_IR = 0, LED_RED = 0;
  logic [3:0] LED_Drive = 0;
  logic [6:0] DC_Comp = 0;
  logic [3:0] PGA_Gain = 0;
  logic [7:0] Vppg;
  logic Vppg_valid;
  logic [9:0] pulse_phase;
  int checks = 0, failures = 0;

  ppg_afe_model dut (
    .CLK(CLK), .rst(rst), .LED_IR(LED_IR), .LED_RED(LED_RED), .LED_Drive(LED_Drive),
    .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain), .Vppg(Vppg), .Vppg_valid(Vppg_valid),
    .pulse_phase(pulse_phase)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic ir, red;
    logic [3:0] drv;
    logic [6:0] comp;
    logic [3:0] gain;
    int exp_v;
  } vec_t;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  task automatic set_in(input logic ir, input logic red, input logic [3:0] drv,
                        input logic [6:0] comp, input logic [3:0] gain);
    LED_IR = ir; LED_RED = red; LED_Drive = drv; DC_Comp = comp; PGA_Gain = gain;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  vec_t vt[14];
  int mx, prevph;
  bit wrapped, done;

  initial begin
    // ac stays 0 for the first 15 phases, so these values involve only the baseline codes
    vt[0]  = '{0, 1, 8,  70,  0, 144};
    vt[1]  = '{0, 1, 8,  70, 15, 255};
    vt[2]  = '{0, 1, 8, 127,  1,   0};
    vt[3]  = '{0, 0, 0,   0,  0, 135};
    vt[4]  = '{1, 0, 8,  70,  0, 167};
    vt[5]  = '{1, 1, 8, 127,  0, 210};
    vt[6]  = '{1, 1, 15, 127, 3, 255};
    vt[7]  = '{0, 1, 0,   0,  0, 144};
    vt[8]  = '{0, 1, 0,  10,  1, 121};
    vt[9]  = '{0, 1, 0,   9,  1, 125};
    vt[10] = '{1, 0, 3,  50,  2,  67};
    vt[11] = '{0, 0, 5,   4,  7, 127};
    vt[12] = '{0, 0, 0,   0, 15, 255};
    vt[13] = '{0, 1, 8,  78, 15, 143};
    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].ir, vt[i].red, vt[i].drv, vt[i].comp, vt[i].gain);
      do_reset();
      for (int n = 0; n < 8; n++) step();
      chk($sformatf("vec%0d_vppg", i), Vppg, vt[i].exp_v);
      chk($sformatf("vec%0d_valid", i), Vppg_valid, 1);
    end

    // reset release, settle timing, then 3-cycle pipeline latency and both saturations
    set_in(0, 1, 8, 70, 0);
    rst = 1;
    step();
    step();
    chk("rst_vppg", Vppg, 127);
    chk("rst_valid", Vppg_valid, 0);
    chk("rst_phase", pulse_phase, 0);
    rst = 0;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk($sformatf("settle_valid_e%0d", n), Vppg_valid, n == 5);
      if (n == 4) chk("settle_hold_vppg", Vppg, 127);
    end
    chk("first_valid_vppg", Vppg, 144);
    for (int n = 6; n <= 10; n++) step();
    PGA_Gain = 15;
    step();
    step();
    chk("lat_gain_e12", Vppg, 144);
    step();
    chk("lat_gain_e13", Vppg, 255);
    DC_Comp = 127; PGA_Gain = 1;
    step();
    step();
    chk("lat_comp_e15", Vppg, 255);
    step();
    chk("lat_comp_e16", Vppg, 0);

    // LED toggling: hold frozen, valid low exactly SETTLE_CYC cycles
    set_in(0, 1, 8, 70, 0);
    do_reset();
    for (int n = 1; n <= 10; n++) step();
    LED_IR = 1; LED_RED = 0;
    for (int n = 11; n <= 14; n++) begin
      step();
      chk($sformatf("tog1_valid_e%0d", n), Vppg_valid, 0);
      chk($sformatf("tog1_hold_e%0d", n), Vppg, 144);
    end
    step();
    chk("tog1_valid_e15", Vppg_valid, 1);
    chk("tog1_vppg_e15", Vppg, 167);
    for (int n = 16; n <= 20; n++) step();
    chk("ir_ac1_e20", Vppg, 168);
    LED_IR = 0; LED_RED = 1;
    for (int n = 21; n <= 24; n++) begin
      step();
      chk($sformatf("tog2_valid_e%0d", n), Vppg_valid, 0);
      chk($sformatf("tog2_hold_e%0d", n), Vppg, 168);
    end
    step();
    chk("tog2_valid_e25", Vppg_valid, 1);
    chk("tog2_vppg_e25", Vppg, 145);
    for (int n = 26; n <= 30; n++) step();
    LED_Drive = 7;
    step();
    step();
    LED_Drive = 8;
    for (int n = 33; n <= 36; n++) step();
    chk("restart_valid_e36", Vppg_valid, 0);
    chk("restart_hold_e36", Vppg, 145);
    step();
    chk("restart_valid_e37", Vppg_valid, 1);
    chk("restart_vppg_e37", Vppg, 146);

    // one full period: peak, wrap, return to baseline
    set_in(0, 1, 8, 70, 0);
    do_reset();
    mx = 0; wrapped = 0; done = 0;
    for (int i = 0; i < 1100 && !done; i++) begin
      prevph = int'(pulse_phase);
      step();
      if (int'(Vppg) > mx) mx = int'(Vppg);
      if (!wrapped && pulse_phase == 10'd503) chk("peak_at_503", Vppg, 179);
      if (prevph == 999) begin
        chk("wrap_to_0", pulse_phase, 0);
        wrapped = 1;
      end
      if (wrapped && pulse_phase == 10'd3) begin
        chk("post_wrap_vppg", Vppg, 144);
        done = 1;
      end
    end
    chk("period_completed", done, 1);
    chk("peak_max", mx, 179);

    // reset asserted mid-pulse
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      if (pulse_phase == 10'd437) done = 1;
    end
    chk("reached_437", done, 1);
    rst = 1;
    step();
    chk("midrst_phase", pulse_phase, 0);
    chk("midrst_vppg", Vppg, 127);
    chk("midrst_valid", Vppg_valid, 0);
    chk("midrst_acc", dut.ac_acc_q, 0);
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
